// File: rtl/gate_bist_ctrl_pkg.sv
// gate_bist_ctrl shared definitions
// FSM states, default stimulus constants, width helper
package gate_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } bist_state_t;

  localparam logic [4:0] BIST_DEFAULT_PATTERN = 5'b10110;
  localparam int         BIST_DEFAULT_SETTLE  = 2;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_settle.sv
// bist_settle_timer: loadable down-counter
// expired flags the last settle cycle (count==1)
module bist_settle_timer
  import gate_bist_ctrl_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // load wins; otherwise count down and stop at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST sequencer for a 1-bit gate
// drives dut_a per vector, samples dut_y after settle
module gate_bist_ctrl
  import gate_bist_ctrl_pkg::*;
#(
  parameter int                     NUM_VECTORS   = 5,
  parameter logic [NUM_VECTORS-1:0] PATTERN       = BIST_DEFAULT_PATTERN,
  parameter int                     SETTLE_CYCLES = BIST_DEFAULT_SETTLE,
  parameter bit                     EXPECT_INVERT = 1'b1,
  localparam int EW = clog2_min1(NUM_VECTORS + 1),
  localparam int IW = clog2_min1(NUM_VECTORS),
  localparam int TW = clog2_min1(SETTLE_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          dut_a,
  input  logic          dut_y,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [EW-1:0] err_count,
  output logic [IW-1:0] fail_index,
  output logic [IW-1:0] vec_idx
);

  bist_state_t state;
  logic        timer_load;
  logic        expired;
  logic        expect_y;
  logic        mismatch;
  logic        last_vec;

  assign timer_load = (state == ST_APPLY);
  assign expect_y   = EXPECT_INVERT ? ~dut_a : dut_a;
  assign mismatch   = (dut_y != expect_y);
  assign last_vec   = (vec_idx == IW'(NUM_VECTORS - 1));

  bist_settle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (TW'(SETTLE_CYCLES)),
    .expired  (expired)
  );

  // sequencer FSM with registered drive and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dut_a      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_index <= '0;
      vec_idx    <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_APPLY;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_index <= '0;
            vec_idx    <= '0;
          end
        end
        ST_APPLY: begin
          dut_a <= PATTERN[vec_idx];
          state <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (expired) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              fail_index <= vec_idx;
            end
          end
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            vec_idx <= vec_idx + 1'b1;
            state   <= ST_APPLY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
